des_keyspace_scheduler: RTL and testbench



---
 rtl/des_sched_pkg.sv | 24 ++
 rtl/des_rr_arbiter.sv | 30 +++
 rtl/des_keyspace_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_des_keyspace_scheduler.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_sched_pkg.sv
// Shared constants and FSM state encoding for the DES keyspace scheduler.
package des_sched_pkg;

    localparam int KEY_W_DEF   = 56;
    localparam int CHUNK_W_DEF = 24;
    localparam int CIDX_W_DEF  = KEY_W_DEF - CHUNK_W_DEF;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE     = 2'd0;
    localparam sched_state_t ST_DISPATCH = 2'd1;
    localparam sched_state_t ST_DRAIN    = 2'd2;
    localparam sched_state_t ST_DONE     = 2'd3;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/des_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping at N.
module des_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/des_keyspace_scheduler.sv
// Splits a DES key range into chunks, dispatches them round-robin to cracker
// cores, tracks completion and funnels per-core finds into one result stream.
module des_keyspace_scheduler
    import des_sched_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF,
    parameter int CIDX_W  = KEY_W - CHUNK_W
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     cfg_start,
    input  logic                     cfg_abort,
    input  logic                     cfg_stop_on_found,
    input  logic [CIDX_W-1:0]        cfg_chunk_first,
    input  logic [CIDX_W-1:0]        cfg_chunk_last,
    output logic                     asg_valid,
    output logic [N_CORES-1:0]       asg_core,
    output logic [KEY_W-1:0]         asg_base,
    output logic                     core_abort,
    input  logic [N_CORES-1:0]       core_done,
    input  logic [N_CORES-1:0]       core_found,
    input  logic [N_CORES*KEY_W-1:0] core_found_key,
    output logic                     found_valid,
    input  logic                     found_ready,
    output logic [KEY_W-1:0]         found_key,
    output logic [3:0]               found_core,
    output logic                     st_busy,
    output logic                     st_done,
    output logic                     st_err,
    output logic [31:0]              chunks_issued,
    output logic [31:0]              chunks_done
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    sched_state_t        state;
    logic [N_CORES-1:0]  busy;
    logic [PTR_W-1:0]    rr_ptr;
    logic [CIDX_W:0]     next_idx;
    logic [CIDX_W:0]     last_idx;
    logic                stop_latched;
    logic [N_CORES-1:0]  pend_valid;
    logic [KEY_W-1:0]    pend_key [N_CORES];
    logic [PTR_W-1:0]    found_idx;

    logic [N_CORES-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_any;
    logic                stop_hit;
    logic                do_grant;
    logic [CIDX_W:0]     next_idx_n;
    logic [N_CORES-1:0]  busy_n;
    logic [N_CORES-1:0]  done_ok;
    logic [N_CORES-1:0]  done_bad;
    logic                pop;
    logic                start_ok;
    logic                start_bad;
    logic                can_start;
    logic [N_CORES-1:0]  pend_valid_n;
    logic [KEY_W-1:0]    pend_key_n [N_CORES];
    logic                find_err;
    logic                sel_valid;
    logic [PTR_W-1:0]    sel_idx;
    logic [KEY_W-1:0]    sel_key;

    des_rr_arbiter #(
        .N     (N_CORES),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req       (~busy),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A find with stop-on-found latched suppresses the grant in that same cycle.
    assign stop_hit   = stop_latched && (|core_found);
    assign do_grant   = (state == ST_DISPATCH) && grant_any && (next_idx <= last_idx)
                        && !stop_hit && !cfg_abort;
    assign next_idx_n = next_idx + {{CIDX_W{1'b0}}, do_grant};
    assign busy_n     = (busy & ~core_done) | (do_grant ? grant : '0);
    assign done_ok    = core_done & busy;
    assign done_bad   = core_done & ~busy;
    assign pop        = found_valid && found_ready;
    assign can_start  = cfg_start && !cfg_abort && ((state == ST_IDLE) || (state == ST_DONE));
    assign start_ok   = can_start && (cfg_chunk_first <= cfg_chunk_last);
    assign start_bad  = can_start && (cfg_chunk_first > cfg_chunk_last);

    assign asg_valid  = do_grant;
    assign asg_core   = do_grant ? grant : '0;
    assign asg_base   = {next_idx[CIDX_W-1:0], {CHUNK_W{1'b0}}};
    assign found_core = 4'(found_idx);
    assign st_busy    = (state == ST_DISPATCH) || (state == ST_DRAIN);
    assign st_done    = (state == ST_DONE);

    // The pop frees its slot before new finds are considered, so a core may
    // refill the entry being consumed in the same cycle.
    always_comb begin
        pend_valid_n = pend_valid;
        find_err     = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            pend_key_n[i] = pend_key[i];
        end
        if (pop) begin
            pend_valid_n[found_idx] = 1'b0;
        end
        for (int i = 0; i < N_CORES; i++) begin
            if (core_found[i]) begin
                if (pend_valid_n[i]) begin
                    find_err = 1'b1;
                end else begin
                    pend_valid_n[i] = 1'b1;
                    pend_key_n[i]   = core_found_key[i*KEY_W +: KEY_W];
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_key   = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (pend_valid_n[i]) begin
                sel_valid = 1'b1;
                sel_idx   = PTR_W'(i);
                sel_key   = pend_key_n[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= ST_IDLE;
            busy          <= '0;
            rr_ptr        <= '0;
            next_idx      <= '0;
            last_idx      <= '0;
            stop_latched  <= 1'b0;
            pend_valid    <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                pend_key[i] <= '0;
            end
            found_valid   <= 1'b0;
            found_key     <= '0;
            found_idx     <= '0;
            core_abort    <= 1'b0;
            st_err        <= 1'b0;
            chunks_issued <= '0;
            chunks_done   <= '0;
        end else begin
            core_abort <= cfg_abort;
            if (cfg_abort) begin
                state       <= ST_IDLE;
                busy        <= '0;
                rr_ptr      <= '0;
                pend_valid  <= '0;
                found_valid <= 1'b0;
                found_key   <= '0;
                found_idx   <= '0;
            end else begin
                busy       <= busy_n;
                pend_valid <= pend_valid_n;
                for (int i = 0; i < N_CORES; i++) begin
                    pend_key[i] <= pend_key_n[i];
                end
                found_valid <= sel_valid;
                found_key   <= sel_key;
                found_idx   <= sel_idx;
                next_idx    <= next_idx_n;
                if (do_grant) begin
                    rr_ptr <= (grant_idx == PTR_W'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;
                end
                chunks_issued <= start_ok ? '0 : chunks_issued + 32'(do_grant);
                chunks_done   <= start_ok ? '0 : chunks_done + 32'(popcount16(16'(done_ok)));
                st_err        <= (start_ok ? 1'b0 : st_err) | start_bad | (|done_bad) | find_err;

                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start_ok) begin
                            state        <= ST_DISPATCH;
                            next_idx     <= {1'b0, cfg_chunk_first};
                            last_idx     <= {1'b0, cfg_chunk_last};
                            stop_latched <= cfg_stop_on_found;
                        end else if (start_bad) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DISPATCH: begin
                        if (stop_hit || (next_idx_n > last_idx)) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if ((busy_n == '0) && (pend_valid_n == '0)) begin
                            state <= ST_DONE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_des_keyspace_scheduler.sv
// Directed bench for des_keyspace_scheduler with a cycle-level reference model
// of the dispatch, completion and find-collection rules.
module tb_des_keyspace_scheduler;

    localparam int N        = 4;
    localparam int KW       = 56;
    localparam int CIW      = 32;
    localparam int DONE_DLY = 10;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic            cfg_start;
    logic            cfg_abort;
    logic            cfg_stop_on_found;
    logic [CIW-1:0]  cfg_chunk_first;
    logic [CIW-1:0]  cfg_chunk_last;
    logic            asg_valid;
    logic [N-1:0]    asg_core;
    logic [KW-1:0]   asg_base;
    logic            core_abort;
    logic [N-1:0]    core_done = '0;
    logic [N-1:0]    core_found;
    logic [N*KW-1:0] core_found_key;
    logic            found_valid;
    logic            found_ready;
    logic [KW-1:0]   found_key;
    logic [3:0]      found_core;
    logic            st_busy;
    logic            st_done;
    logic            st_err;
    logic [31:0]     chunks_issued;
    logic [31:0]     chunks_done;

    des_keyspace_scheduler #(.N_CORES(N)) dut (
        .ACLK              (ACLK),
        .ARESETN           (ARESETN),
        .cfg_start         (cfg_start),
        .cfg_abort         (cfg_abort),
        .cfg_stop_on_found (cfg_stop_on_found),
        .cfg_chunk_first   (cfg_chunk_first),
        .cfg_chunk_last    (cfg_chunk_last),
        .asg_valid         (asg_valid),
        .asg_core          (asg_core),
        .asg_base          (asg_base),
        .core_abort        (core_abort),
        .core_done         (core_done),
        .core_found        (core_found),
        .core_found_key    (core_found_key),
        .found_valid       (found_valid),
        .found_ready       (found_ready),
        .found_key         (found_key),
        .found_core        (found_core),
        .st_busy           (st_busy),
        .st_done           (st_done),
        .st_err            (st_err),
        .chunks_issued     (chunks_issued),
        .chunks_done       (chunks_done)
    );

    always #5 ACLK = ~ACLK;

    int vec_count = 0;
    int err_count = 0;
    bit cmp_en    = 1'b0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Core emulation: each assigned core reports done DONE_DLY cycles later.
    int             due [N] = '{default: -1};
    int             cyc     = 0;
    logic [KW-1:0]  log_base [$];
    logic [N-1:0]   log_core [$];

    always begin
        @(negedge ACLK);
        if (core_abort === 1'b1) begin
            for (int i = 0; i < N; i++) due[i] = -1;
        end
        if (asg_valid === 1'b1) begin
            log_base.push_back(asg_base);
            log_core.push_back(asg_core);
            for (int i = 0; i < N; i++) begin
                if (asg_core[i]) due[i] = cyc + DONE_DLY;
            end
        end
        @(posedge ACLK);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            core_done[i] = (due[i] == cyc);
            if (due[i] == cyc) due[i] = -1;
        end
    end

    // Reference model: phase 0 idle, 1 dispatch, 2 drain, 3 done.
    int            m_phase = 0;
    bit            m_busy [N];
    bit            m_pend_v [N];
    logic [KW-1:0] m_pend_k [N];
    int            m_ptr = 0;
    longint        m_next = 0;
    longint        m_last = 0;
    bit            m_stop = 1'b0;
    int            m_issued = 0;
    int            m_done = 0;
    bit            m_err = 1'b0;
    bit            m_abort_pulse = 1'b0;

    always @(negedge ACLK) begin
        bit exp_grant;
        bit stop_hit;
        bit new_err;
        bit any_busy;
        bit any_pend;
        int exp_core;
        int lowest;
        int c;

        lowest = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_pend_v[i]) lowest = i;
        end
        stop_hit  = m_stop && (|core_found);
        exp_grant = 1'b0;
        exp_core  = 0;
        if (m_phase == 1 && m_next <= m_last && !stop_hit && !cfg_abort) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!exp_grant && !m_busy[c]) begin
                    exp_grant = 1'b1;
                    exp_core  = c;
                end
            end
        end

        if (cmp_en) begin
            check_output("asg_valid", asg_valid, exp_grant);
            if (exp_grant) begin
                check_output("asg_core", asg_core, 64'(1) << exp_core);
                check_output("asg_base", asg_base, 64'(m_next) << 24);
            end
            check_output("core_abort", core_abort, m_abort_pulse);
            check_output("st_busy", st_busy, (m_phase == 1 || m_phase == 2));
            check_output("st_done", st_done, (m_phase == 3));
            check_output("st_err", st_err, m_err);
            check_output("chunks_issued", chunks_issued, m_issued);
            check_output("chunks_done", chunks_done, m_done);
            check_output("found_valid", found_valid, (lowest >= 0));
            if (lowest >= 0) begin
                check_output("found_core", found_core, lowest);
                check_output("found_key", found_key, m_pend_k[lowest]);
            end
        end

        if (!ARESETN) begin
            m_phase = 0; m_ptr = 0; m_next = 0; m_last = 0; m_stop = 0;
            m_issued = 0; m_done = 0; m_err = 0; m_abort_pulse = 0;
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0; m_pend_v[i] = 0; m_pend_k[i] = '0;
            end
        end else begin
            m_abort_pulse = cfg_abort;
            if (cfg_abort) begin
                m_phase = 0;
                m_ptr   = 0;
                for (int i = 0; i < N; i++) begin
                    m_busy[i] = 0; m_pend_v[i] = 0;
                end
            end else begin
                new_err = 1'b0;
                if (lowest >= 0 && found_ready) m_pend_v[lowest] = 0;
                for (int i = 0; i < N; i++) begin
                    if (core_found[i]) begin
                        if (m_pend_v[i]) new_err = 1'b1;
                        else begin
                            m_pend_v[i] = 1;
                            m_pend_k[i] = core_found_key[i*KW +: KW];
                        end
                    end
                    if (core_done[i]) begin
                        if (m_busy[i]) begin
                            m_busy[i] = 0;
                            m_done++;
                        end else new_err = 1'b1;
                    end
                end
                if (exp_grant) begin
                    m_busy[exp_core] = 1;
                    m_next++;
                    m_issued++;
                    m_ptr = (exp_core + 1) % N;
                end
                any_busy = 1'b0;
                any_pend = 1'b0;
                for (int i = 0; i < N; i++) begin
                    any_busy |= m_busy[i];
                    any_pend |= m_pend_v[i];
                end
                if (m_phase == 0 || m_phase == 3) begin
                    if (cfg_start) begin
                        if (cfg_chunk_first > cfg_chunk_last) begin
                            new_err = 1'b1;
                            m_phase = 3;
                        end else begin
                            m_next   = longint'(cfg_chunk_first);
                            m_last   = longint'(cfg_chunk_last);
                            m_stop   = cfg_stop_on_found;
                            m_issued = 0;
                            m_done   = 0;
                            m_err    = 0;
                            m_phase  = 1;
                        end
                    end
                end else if (m_phase == 1) begin
                    if (stop_hit || m_next > m_last) m_phase = 2;
                end else if (m_phase == 2) begin
                    if (!any_busy && !any_pend) m_phase = 3;
                end
                m_err = m_err | new_err;
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [CIW-1:0] first, input logic [CIW-1:0] last, input logic stop);
        tick();
        cfg_chunk_first   = first;
        cfg_chunk_last    = last;
        cfg_stop_on_found = stop;
        cfg_start         = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic pulse_found(input logic [N-1:0] mask, input logic [KW-1:0] key_a, input logic [KW-1:0] key_b);
        int n;
        tick();
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                core_found_key[i*KW +: KW] = (n == 0) ? key_a : key_b;
                n++;
            end
        end
        core_found = mask;
        tick();
        core_found = '0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        @(negedge ACLK);
        while (st_done !== 1'b1 && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        check_output(name, st_done, 1);
    endtask

    task automatic wait_issued(input int target, input int bound, input string name);
        int n = 0;
        @(negedge ACLK);
        while (chunks_issued < target && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        check_output(name, (chunks_issued >= target), 1);
    endtask

    task automatic wait_found(input int bound, input string name);
        int n = 0;
        @(negedge ACLK);
        while (found_valid !== 1'b1 && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        check_output(name, found_valid, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [KW-1:0] t1_base [4] = '{56'h0, 56'h1000000, 56'h2000000, 56'h3000000};
    logic [N-1:0]  t1_core [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        int base_idx;
        int log_at_find;

        ARESETN = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_stop_on_found = 1'b0;
        cfg_chunk_first = '0; cfg_chunk_last = '0;
        core_found = '0; core_found_key = '0; found_ready = 1'b0;
        repeat (3) tick();
        ARESETN = 1'b1;
        cmp_en  = 1'b1;
        @(negedge ACLK);
        check_output("reset asg_valid", asg_valid, 0);
        check_output("reset st_busy", st_busy, 0);
        check_output("reset st_done", st_done, 0);
        check_output("reset st_err", st_err, 0);
        check_output("reset chunks_issued", chunks_issued, 0);
        check_output("reset found_valid", found_valid, 0);

        $display("[TB] test 1: range 0..7");
        base_idx = log_base.size();
        apply_stimulus(32'd0, 32'd7, 1'b0);
        wait_done(300, "t1 done");
        check_output("t1 asg count", log_base.size() - base_idx, 8);
        for (int k = 0; k < 4; k++) begin
            check_output("t1 base", log_base[base_idx + k], t1_base[k]);
            check_output("t1 core", log_core[base_idx + k], t1_core[k]);
        end
        check_output("t1 issued", chunks_issued, 8);
        check_output("t1 done count", chunks_done, 8);

        $display("[TB] test 2: first > last");
        base_idx = log_base.size();
        apply_stimulus(32'd5, 32'd4, 1'b0);
        @(negedge ACLK);
        check_output("t2 st_err", st_err, 1);
        check_output("t2 st_done", st_done, 1);
        repeat (3) tick();
        check_output("t2 no asg", log_base.size() - base_idx, 0);

        $display("[TB] test 3: stop on found");
        base_idx = log_base.size();
        apply_stimulus(32'd0, 32'd99, 1'b1);
        wait_issued(6, 200, "t3 six issued");
        pulse_found(4'b0100, 56'h0123456789ABCD, '0);
        @(negedge ACLK);
        log_at_find = log_base.size();
        wait_found(50, "t3 found valid");
        check_output("t3 found_core", found_core, 2);
        check_output("t3 found_key", found_key, 56'h0123456789ABCD);
        tick();
        found_ready = 1'b1;
        tick();
        found_ready = 1'b0;
        wait_done(300, "t3 done");
        check_output("t3 no asg after find", log_base.size(), log_at_find);
        check_output("t3 issued", chunks_issued, log_at_find - base_idx);

        $display("[TB] test 4: simultaneous finds");
        apply_stimulus(32'd0, 32'd3, 1'b0);
        tick();
        pulse_found(4'b1010, 56'h11111111111111, 56'h33333333333333);
        @(negedge ACLK);
        check_output("t4 first valid", found_valid, 1);
        check_output("t4 first core", found_core, 1);
        check_output("t4 first key", found_key, 56'h11111111111111);
        repeat (5) tick();
        found_ready = 1'b1;
        tick();
        found_ready = 1'b0;
        @(negedge ACLK);
        check_output("t4 second core", found_core, 3);
        check_output("t4 second key", found_key, 56'h33333333333333);
        tick();
        found_ready = 1'b1;
        tick();
        found_ready = 1'b0;
        wait_done(300, "t4 done");
        check_output("t4 st_err", st_err, 0);

        $display("[TB] test 5: find overflow");
        pulse_found(4'b0001, 56'h00AAAAAAAAAAAA, '0);
        pulse_found(4'b0001, 56'h00BBBBBBBBBBBB, '0);
        @(negedge ACLK);
        check_output("t5 st_err", st_err, 1);
        check_output("t5 kept key", found_key, 56'h00AAAAAAAAAAAA);
        tick();
        found_ready = 1'b1;
        tick();
        found_ready = 1'b0;
        @(negedge ACLK);
        check_output("t5 drained", found_valid, 0);

        $display("[TB] test 6: abort then full-range last chunk");
        apply_stimulus(32'd0, 32'd99, 1'b0);
        wait_issued(4, 100, "t6 four issued");
        tick();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        @(negedge ACLK);
        check_output("t6 core_abort", core_abort, 1);
        check_output("t6 st_busy", st_busy, 0);
        check_output("t6 issued hold", chunks_issued, 4);
        tick();
        @(negedge ACLK);
        check_output("t6 abort one cycle", core_abort, 0);
        base_idx = log_base.size();
        apply_stimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_done(300, "t6 done");
        check_output("t6 issued", chunks_issued, 1);
        check_output("t6 done count", chunks_done, 1);
        check_output("t6 asg count", log_base.size() - base_idx, 1);
        check_output("t6 base", log_base[log_base.size() - 1], 56'hFFFFFFFF000000);
        check_output("t6 core", log_core[log_core.size() - 1], 4'b0001);
        check_output("t6 st_err", st_err, 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
